// File: rtl/lzc_pkg.sv
// Shared helpers for the pipelined leading-zero counter.
package lzc_pkg;

  // Width of a leading-zero count for an operand of the given width.
  function automatic int lzc_zw(input int width);
    return $clog2(width);
  endfunction

  // Pipeline stage in which merge level l is evaluated.
  function automatic int stage_of_level(input int l, input int stages, input int levels);
    return (l * stages) / levels;
  endfunction

endpackage

// File: rtl/lzc_merge.sv
// One node of the LZC tree: merges the (valid, count) pairs of two halves.
module lzc_merge
  import lzc_pkg::*;
#(
  parameter int ZW = 1
) (
  input  logic          vh,
  input  logic [ZW-1:0] zh,
  input  logic          vl,
  input  logic [ZW-1:0] zl,
  output logic          v,
  output logic [ZW:0]   z
);

  // A set bit in the high half decides the count; otherwise skip the whole high half.
  assign v = vh | vl;
  assign z = vh ? {1'b0, zh} : {1'b1, zl};

endmodule

// File: rtl/lzc_pipe.sv
// Pipelined leading-zero counter with valid/ready handshake, optional
// left-normalised operand output and a sideband tag per operand.
module lzc_pipe
  import lzc_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int NORM   = 1,
  parameter int TAG_W  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           a,
  input  logic [TAG_W-1:0]           tag_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [lzc_zw(WIDTH)-1:0]   Z,
  output logic                       V,
  output logic [WIDTH-1:0]           norm_out,
  output logic [TAG_W-1:0]           tag_out
);

  localparam int L = lzc_zw(WIDTH);

  // Payload held by the final (output) stage register.
  typedef struct packed {
    logic             v;
    logic [L-1:0]     z;
    logic [WIDTH-1:0] norm;
  } result_t;

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] up_v;
  logic [STAGES-1:0] take;
  logic [TAG_W-1:0]  tag_q  [STAGES];
  logic [TAG_W-1:0]  up_tag [STAGES];
  logic              fin_v;
  logic [L-1:0]      fin_z;
  logic [WIDTH-1:0]  fin_norm;
  result_t           res_q;

  // Valid bit offered to each stage by its upstream neighbour.
  assign up_v = STAGES'({vld, in_valid});

  // A stage loads when it, or any stage below it, is empty, or the output fires.
  // Written as a flat reduction so there is no combinational loop through load[].
  for (genvar k = 0; k < STAGES; k++) begin : g_ld
    assign load[k] = out_ready | ~(&vld[STAGES-1:k]);
  end

  // Data registers only capture real operands, so idle cycles never disturb them.
  assign take     = load & up_v;
  assign in_ready = load[0];

  // Stage valid bits: refill from upstream whenever the stage loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else begin
      vld <= (vld & ~load) | (up_v & load);
    end
  end

  // Tag offered to each stage by its upstream neighbour.
  always_comb begin
    up_tag[0] = tag_in;
    for (int k = 1; k < STAGES; k++) begin
      up_tag[k] = tag_q[k-1];
    end
  end

  // Tag registers travel with the operand through every stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (take[k]) begin
          tag_q[k] <= up_tag[k];
        end
      end
    end
  end

  // Merge tree: level l reduces WIDTH>>l bits into WIDTH>>(l+1) (v, z) nodes.
  // A level that is the last one of its stage registers its result; the final
  // level feeds the output register directly.
  for (genvar l = 0; l < L; l++) begin : g_lvl
    localparam int N  = WIDTH >> (l + 1);
    localparam int SL = stage_of_level(l, STAGES, L);

    logic [N-1:0]      cv;
    logic [N-1:0][l:0] cz;

    if (l == 0) begin : g_leaf
      for (genvar n = 0; n < N; n++) begin : g_pair
        assign cv[n] = a[2*n+1] | a[2*n];
        assign cz[n] = ~a[2*n+1];
      end
    end else begin : g_node
      for (genvar n = 0; n < N; n++) begin : g_m
        lzc_merge #(.ZW(l)) u_merge (
          .vh (g_lvl[l-1].g_out.ov[2*n+1]),
          .zh (g_lvl[l-1].g_out.oz[2*n+1]),
          .vl (g_lvl[l-1].g_out.ov[2*n]),
          .zl (g_lvl[l-1].g_out.oz[2*n]),
          .v  (cv[n]),
          .z  (cz[n])
        );
      end
    end

    if (l < L - 1) begin : g_out
      logic [N-1:0]      ov;
      logic [N-1:0][l:0] oz;
      if (stage_of_level(l + 1, STAGES, L) != SL) begin : g_reg
        // Partial tree result captured at the stage boundary.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            ov <= '0;
            oz <= '0;
          end else if (take[SL]) begin
            ov <= cv;
            oz <= cz;
          end
        end
      end else begin : g_thru
        assign ov = cv;
        assign oz = cz;
      end
    end
  end

  assign fin_v = g_lvl[L-1].cv[0];
  assign fin_z = g_lvl[L-1].cz[0];

  if (NORM != 0) begin : g_norm
    logic [WIDTH-1:0] sh_a;
    if (STAGES == 1) begin : g_direct
      assign sh_a = a;
    end else begin : g_carry
      logic [WIDTH-1:0] a_q [STAGES-1];
      // Original operand follows the tree so the last stage can shift it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < STAGES - 1; k++) begin
            a_q[k] <= '0;
          end
        end else begin
          if (take[0]) begin
            a_q[0] <= a;
          end
          for (int k = 1; k < STAGES - 1; k++) begin
            if (take[k]) begin
              a_q[k] <= a_q[k-1];
            end
          end
        end
      end
      assign sh_a = a_q[STAGES-2];
    end
    // A zero operand shifts to zero regardless of the count.
    assign fin_norm = sh_a << fin_z;
  end else begin : g_nonorm
    assign fin_norm = '0;
  end

  // Output register; the raw tree count for a zero operand is forced to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
    end else if (take[STAGES-1]) begin
      res_q.v    <= fin_v;
      res_q.z    <= fin_v ? fin_z : '0;
      res_q.norm <= fin_norm;
    end
  end

  assign out_valid = vld[STAGES-1];
  assign Z         = res_q.z;
  assign V         = res_q.v;
  assign norm_out  = res_q.norm;
  assign tag_out   = tag_q[STAGES-1];

endmodule
